poly_voice_allocator: RTL and testbench
=======================================

// Module: poly_voice_allocator
// PURPOSE
//  Turns a serial stream of note-on/note-off events (from the MIDI parser) into the four
//  per-voice note numbers and gates that feed PolyFreqLookup and the oscillators.
//  Producer end of the note1..note4 interface: tracks voice ownership and allocation age,
//  retriggers repeated notes and releases voices on note-off.
// PARAMETERS
//  NOTE_W     7      note number width; must match the note1..note4 inputs of the lookup
//  REST_NOTE  7'h00  note value loaded into every voice at reset
// PORTS
//  clk        in   1       system clock; all state changes on its rising edge
//  reset      in   1       asynchronous, active-low reset
//  evt_valid  in   1       event present on evt_on/evt_note
//  evt_ready  out  1       block can accept an event this cycle
//  evt_on     in   1       1 = note-on, 0 = note-off
//  evt_note   in   NOTE_W  note number of the event
//  note1..4   out  NOTE_W  note currently held by voice 1..4 (registered)
//  gate       out  4       gate[i] = 1 while voice i+1 is held; bit 0 = voice 1
//  steal      out  1       1-cycle pulse: a held voice was reassigned
//  drop       out  1       1-cycle pulse: a note-on was discarded (no voice available)
// BEHAVIOUR
//  Reset (async, reset=0): note1..4=REST_NOTE, gate=0, steal=0, drop=0, evt_ready=0 while
//   asserted; age[i]=i (voice 4 oldest); FSM -> IDLE. Release is synchronised: evt_ready=1 on
//   the first clk edge after reset goes high.
//  Handshake: event accepted when evt_valid & evt_ready at a rising edge; evt_on/evt_note are
//   captured that edge. evt_ready=1 only in IDLE.
//  FSM: IDLE -(accept)-> MATCH -> UPDATE -> IDLE. One event per 3 cycles max.
//   MATCH: compare captured note against all four voices in parallel; register
//    hit_vec[i] = gate[i] & (note_i == captured note) and free_vec[i] = ~gate[i].
//   UPDATE: apply the rules below; outputs, steal and drop change on the edge leaving UPDATE.
//   Latency: accept at edge N -> outputs valid after edge N+2.
//  Note-on rules, in priority order:
//   1. hit: lowest-index hit voice retriggers; note unchanged, gate held 1; age reset to 0.
//   2. free voice: lowest-index voice with gate=0 takes the note; gate set to 1; age -> 0.
//   3. all held: see CONFIGURATION.
//  Note-off: every voice with a hit releases (gate->0); its note output is held so that
//   envelope release uses the correct pitch. A note-off with no hit is ignored
//   (no pulse, no state change).
//  Age: the four 2-bit ages form a permutation of 0..3 (0 = newest). When voice v is
//   (re)assigned at age k, every voice with age < k increments and v gets 0. Note-off
//   leaves ages unchanged; the permutation is preserved.
//  steal/drop: high for exactly the one cycle after UPDATE; never both high.
//  Reset asserted mid-operation: the in-flight event is lost and every register
//   returns to its reset value immediately.
// CONFIGURATION
//  VOICE_STEAL_EN defined: a note-on with all four voices held reassigns the voice with
//   age==3; the new note is written, gate stays 1, age -> 0, steal pulses.
//  VOICE_STEAL_EN undefined: the same note-on is discarded; voices and ages are unchanged,
//   drop pulses. The steal output is tied 0.
// TESTING
//  Reset, then on 3C,40,43: note1..3 = 3C,40,43; gate = 4'b0111; each result visible
//   2 edges after accept.
//  Repeat on 40 with gate = 4'b0111: gate unchanged; voice 2 age -> 0; no steal and
//   no drop pulse.
//  off 40 with gate = 4'b0111: gate = 4'b0101, note2 stays 40; an off for unheld 50
//   changes nothing.
//  Fill four voices (3C,40,43,48), then on 4C: with VOICE_STEAL_EN, note1 = 4C and steal
//   pulses once; without it, no change and drop pulses once.
//  Hold evt_valid=1 continuously: accepts occur on every third edge; evt_note held
//   steady for 2 cycles is not captured twice.
//  Assert reset during MATCH: all outputs go to reset values at once; the event produces
//   no effect after release.

Source files
------------

// File: rtl/poly_voice_allocator.sv
// Four-voice note allocator: note-on/off events -> per-voice note numbers and gates.
// Define VOICE_STEAL_EN to reassign the oldest voice when all four are held.
module poly_voice_allocator #(
    parameter int unsigned          NOTE_W    = 7,
    parameter logic [NOTE_W-1:0]    REST_NOTE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              evt_valid,
    output logic              evt_ready,
    input  logic              evt_on,
    input  logic [NOTE_W-1:0] evt_note,
    output logic [NOTE_W-1:0] note1,
    output logic [NOTE_W-1:0] note2,
    output logic [NOTE_W-1:0] note3,
    output logic [NOTE_W-1:0] note4,
    output logic [3:0]        gate,
    output logic              steal,
    output logic              drop
);

    localparam int unsigned NV = 4;

    typedef enum logic [1:0] {IDLE, MATCH, UPDATE} state_t;

    state_t            state, state_nx;
    logic              accept_c;
    logic              cap_on;
    logic [NOTE_W-1:0] cap_note;
    logic [NV-1:0]     hit_vec, free_vec;
    logic [NOTE_W-1:0] note_r [NV];
    logic [NOTE_W-1:0] note_c [NV];
    logic [1:0]        age_r  [NV];
    logic [1:0]        age_c  [NV];
    logic [NV-1:0]     gate_r, gate_c;
    logic              drop_r, drop_c, ready_c;
    logic [1:0]        hit_idx, free_idx, vsel;
    logic              assign_en;
`ifdef VOICE_STEAL_EN
    logic              steal_r, steal_c;
    logic [1:0]        old_idx;
`endif

    assign accept_c = evt_valid & evt_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept_c) state_nx = MATCH;
            MATCH:   state_nx = UPDATE;
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Event capture and parallel voice compare
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_on   <= 1'b0;
            cap_note <= '0;
            hit_vec  <= '0;
            free_vec <= '0;
        end else begin
            if (accept_c) begin
                cap_on   <= evt_on;
                cap_note <= evt_note;
            end
            if (state == MATCH) begin
                for (int i = 0; i < NV; i++)
                    hit_vec[i] <= gate_r[i] & (note_r[i] == cap_note);
                free_vec <= ~gate_r;
            end
        end
    end

    // Lowest-index priority encoders (and the oldest voice when stealing)
    always_comb begin
        hit_idx  = 2'd0;
        free_idx = 2'd0;
`ifdef VOICE_STEAL_EN
        old_idx  = 2'd0;
`endif
        for (int i = NV - 1; i >= 0; i--) begin
            if (hit_vec[i])  hit_idx  = 2'(i);
            if (free_vec[i]) free_idx = 2'(i);
`ifdef VOICE_STEAL_EN
            if (age_r[i] == 2'd3) old_idx = 2'(i);
`endif
        end
    end

    always_comb begin
        note_c    = note_r;
        gate_c    = gate_r;
        age_c     = age_r;
        drop_c    = 1'b0;
        ready_c   = (state_nx == IDLE);
        assign_en = 1'b0;
        vsel      = 2'd0;
`ifdef VOICE_STEAL_EN
        steal_c   = 1'b0;
`endif
        if (state == UPDATE) begin
            if (cap_on) begin
                if (|hit_vec) begin
                    vsel      = hit_idx;
                    assign_en = 1'b1;
                end else if (|free_vec) begin
                    vsel         = free_idx;
                    assign_en    = 1'b1;
                    note_c[vsel] = cap_note;
                    gate_c[vsel] = 1'b1;
                end else begin
`ifdef VOICE_STEAL_EN
                    vsel         = old_idx;
                    assign_en    = 1'b1;
                    note_c[vsel] = cap_note;
                    steal_c      = 1'b1;
`else
                    drop_c       = 1'b1;
`endif
                end
                // Newer voices than the reassigned one age by one; it becomes newest
                if (assign_en) begin
                    for (int i = 0; i < NV; i++) begin
                        if (2'(i) == vsel)         age_c[i] = 2'd0;
                        else if (age_r[i] < age_r[vsel]) age_c[i] = age_r[i] + 2'd1;
                    end
                end
            end else begin
                gate_c = gate_r & ~hit_vec;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NV; i++) begin
                note_r[i] <= REST_NOTE;
                age_r[i]  <= 2'(i);
            end
            gate_r    <= '0;
            drop_r    <= 1'b0;
            evt_ready <= 1'b0;
        end else begin
            note_r    <= note_c;
            age_r     <= age_c;
            gate_r    <= gate_c;
            drop_r    <= drop_c;
            evt_ready <= ready_c;
        end
    end

`ifdef VOICE_STEAL_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) steal_r <= 1'b0;
        else        steal_r <= steal_c;
    end
    assign steal = steal_r;
`else
    assign steal = 1'b0;
`endif

    assign note1 = note_r[0];
    assign note2 = note_r[1];
    assign note3 = note_r[2];
    assign note4 = note_r[3];
    assign gate  = gate_r;
    assign drop  = drop_r;

endmodule

// File: tb/tb_poly_voice_allocator.sv
// Directed bench for poly_voice_allocator; checks both VOICE_STEAL_EN builds.
module tb_poly_voice_allocator;

    logic       clk = 1'b0;
    logic       reset;
    logic       evt_valid, evt_ready, evt_on;
    logic [6:0] evt_note;
    logic [6:0] note1, note2, note3, note4;
    logic [3:0] gate;
    logic       steal, drop;
    int         n_assert = 0;
    int         n_fail   = 0;

    poly_voice_allocator dut (
        .clk(clk), .reset(reset), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_on(evt_on), .evt_note(evt_note), .note1(note1), .note2(note2),
        .note3(note3), .note4(note4), .gate(gate), .steal(steal), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Returns at accept edge + 2 cycles (+#1), when the result is visible
    task automatic send(input logic on, input logic [6:0] n);
        int w = 0;
        while (!evt_ready && w < 10) begin
            tick();
            w++;
        end
        if (!evt_ready) chk("ready_timeout", 32'(evt_ready), 32'd1);
        evt_valid = 1'b1;
        evt_on    = on;
        evt_note  = n;
        tick();
        evt_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b0; evt_valid = 1'b0; evt_on = 1'b0; evt_note = 7'h00;
        #3;
        chk("rst_gate",  32'(gate),      32'h0);
        chk("rst_note1", 32'(note1),     32'h0);
        chk("rst_note4", 32'(note4),     32'h0);
        chk("rst_ready", 32'(evt_ready), 32'h0);
        chk("rst_pulse", 32'({steal, drop}), 32'h0);
        tick();
        reset = 1'b1;
        #2;
        chk("ready_before_edge", 32'(evt_ready), 32'h0);
        tick();
        chk("ready_after_edge", 32'(evt_ready), 32'h1);

        // First note: not visible one edge after accept, visible after two
        evt_valid = 1'b1; evt_on = 1'b1; evt_note = 7'h3C;
        tick();
        evt_valid = 1'b0;
        chk("ready_low_match", 32'(evt_ready), 32'h0);
        tick();
        chk("lat_note1_early", 32'(note1), 32'h0);
        chk("lat_gate_early",  32'(gate),  32'h0);
        tick();
        chk("lat_note1", 32'(note1), 32'h3C);
        chk("lat_gate",  32'(gate),  32'h1);
        send(1'b1, 7'h40);
        send(1'b1, 7'h43);
        chk("on3_note2", 32'(note2), 32'h40);
        chk("on3_note3", 32'(note3), 32'h43);
        chk("on3_gate",  32'(gate),  32'h7);

        send(1'b1, 7'h40);
        chk("rep_gate",  32'(gate),  32'h7);
        chk("rep_note2", 32'(note2), 32'h40);
        chk("rep_pulse", 32'({steal, drop}), 32'h0);

        send(1'b0, 7'h40);
        chk("off_gate",  32'(gate),  32'h5);
        chk("off_note2", 32'(note2), 32'h40);
        send(1'b0, 7'h50);
        chk("offmiss_gate",  32'(gate),  32'h5);
        chk("offmiss_pulse", 32'({steal, drop}), 32'h0);
        chk("offmiss_note3", 32'(note3), 32'h43);

        // Refill voice 2 (lowest free) with a new note
        send(1'b1, 7'h41);
        chk("refill_note2", 32'(note2), 32'h41);
        chk("refill_gate",  32'(gate),  32'h7);

        // Fresh fill of all four voices, then overflow
        do_reset();
        send(1'b1, 7'h3C);
        send(1'b1, 7'h40);
        send(1'b1, 7'h43);
        send(1'b1, 7'h48);
        chk("fill_gate",  32'(gate),  32'hF);
        chk("fill_note4", 32'(note4), 32'h48);
        send(1'b1, 7'h4C);
`ifdef VOICE_STEAL_EN
        chk("ovf_note1", 32'(note1), 32'h4C);
        chk("ovf_steal", 32'(steal), 32'h1);
`else
        chk("ovf_note1", 32'(note1), 32'h3C);
        chk("ovf_drop",  32'(drop),  32'h1);
`endif
        chk("ovf_gate", 32'(gate), 32'hF);
        chk("ovf_excl", 32'(steal & drop), 32'h0);
        tick();
        chk("ovf_pulse_end", 32'({steal, drop}), 32'h0);

        // Retrigger voice 2 so voice 3 becomes oldest, then overflow again
        send(1'b1, 7'h40);
        chk("age_retrig_pulse", 32'({steal, drop}), 32'h0);
        send(1'b1, 7'h50);
`ifdef VOICE_STEAL_EN
        chk("age_note3", 32'(note3), 32'h50);
        chk("age_note2", 32'(note2), 32'h40);
        chk("age_steal", 32'(steal), 32'h1);
`else
        chk("age_note3", 32'(note3), 32'h43);
        chk("age_drop",  32'(drop),  32'h1);
`endif

        // Continuous valid: accepts only every third edge
        do_reset();
        evt_valid = 1'b1; evt_on = 1'b1; evt_note = 7'h20;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("stream_ready_%0d", i), 32'(evt_ready), 32'((i % 3) == 2));
            if (i == 2) evt_note = 7'h21;
            if (i == 5) evt_note = 7'h22;
        end
        evt_valid = 1'b0;
        chk("stream_gate",  32'(gate),  32'h7);
        chk("stream_note1", 32'(note1), 32'h20);
        chk("stream_note2", 32'(note2), 32'h21);
        chk("stream_note3", 32'(note3), 32'h22);

        // Reset during MATCH: immediate clear, event lost
        evt_valid = 1'b1; evt_note = 7'h30;
        tick();
        evt_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_gate",  32'(gate),      32'h0);
        chk("midrst_note1", 32'(note1),     32'h0);
        chk("midrst_ready", 32'(evt_ready), 32'h0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("midrst_after_gate",  32'(gate),  32'h0);
        chk("midrst_after_note4", 32'(note4), 32'h0);
        chk("midrst_after_ready", 32'(evt_ready), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
